debounce_array: RTL



---
 rtl/debounce_array.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/debounce_array.sv
// -----------------------------------------------------------------------------
// debounce_array
//
// Multi-channel button debouncer for the board-level input path. Every channel
// has its own 2-FF synchroniser and a symmetric consecutive-sample filter.
// Press and release therefore both have to be stable for SAMPLES clk_flag
// ticks before the debounced level changes. Each channel also produces
// registered press/release edge pulses and a one-shot long-press pulse.
//
// Parameters:
//   CH          number of independent channels (>= 1)
//   SAMPLES     consecutive differing ticks needed to change o_btn (>= 1)
//   HOLD_TICKS  ticks o_btn must stay pressed before o_long fires (0 = off)
//   ACTIVE_LOW  1: i_btn is pressed-low and is inverted before the synchroniser
//
// Ports:
//   sys_clk    in   system clock, rising edge
//   sys_rst    in   synchronous active-high reset
//   clk_flag   in   one-cycle sampling tick; filter and hold counters step on it
//   i_btn      in   [CH] raw asynchronous button inputs
//   o_btn      out  [CH] debounced level, 1 = pressed
//   o_press    out  [CH] one-cycle pulse, coincident with o_btn going 0->1
//   o_release  out  [CH] one-cycle pulse, coincident with o_btn going 1->0
//   o_long     out  [CH] one-cycle pulse once a press has lasted HOLD_TICKS ticks
// -----------------------------------------------------------------------------
module debounce_array #(
    parameter int CH         = 4,
    parameter int SAMPLES    = 3,
    parameter int HOLD_TICKS = 1000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          clk_flag,
    input  logic [CH-1:0] i_btn,
    output logic [CH-1:0] o_btn,
    output logic [CH-1:0] o_press,
    output logic [CH-1:0] o_release,
    output logic [CH-1:0] o_long
);

    localparam int CNT_W   = $clog2(SAMPLES + 1);
    localparam bit LONG_EN = (HOLD_TICKS > 0);
    // The hold counter still needs one bit when the long-press feature is off.
    localparam int HOLD_W  = LONG_EN ? $clog2(HOLD_TICKS + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SAMPLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_EN ? HOLD_TICKS - 1 : 0);

    // Polarity-corrected raw input: 1 always means pressed from here on.
    logic [CH-1:0] in_n;
    assign in_n = i_btn ^ {CH{ACTIVE_LOW}};

    logic [CH-1:0]     s1_q, s1_d;
    logic [CH-1:0]     s2_q, s2_d;
    logic [CH-1:0]     btn_q, btn_d;
    logic [CH-1:0]     press_q, press_d;
    logic [CH-1:0]     release_q, release_d;
    logic [CH-1:0]     long_q, long_d;
    logic [CNT_W-1:0]  cnt_q  [CH];
    logic [CNT_W-1:0]  cnt_d  [CH];
    logic [HOLD_W-1:0] hold_q [CH];
    logic [HOLD_W-1:0] hold_d [CH];

    // NOTE: every signal assigned in this block gets a default before any
    // conditional assignment, so no path can leave a value unassigned and
    // infer a latch.
    always_comb begin
        // The synchroniser runs every cycle, regardless of clk_flag.
        s1_d = in_n;
        s2_d = s1_q;

        for (int c = 0; c < CH; c++) begin
            cnt_d[c]     = cnt_q[c];
            btn_d[c]     = btn_q[c];
            hold_d[c]    = '0;
            long_d[c]    = 1'b0;

            // Consecutive-sample filter: any agreeing sample restarts the count.
            if (clk_flag) begin
                if (s2_q[c] == btn_q[c]) begin
                    cnt_d[c] = '0;
                end else if (cnt_q[c] == CNT_LAST) begin
                    btn_d[c] = s2_q[c];
                    cnt_d[c] = '0;
                end else begin
                    cnt_d[c] = cnt_q[c] + CNT_W'(1);
                end
            end

            // Edge pulses are derived from the next state, so they register on
            // the same edge as the o_btn change.
            press_d[c]   =  btn_d[c] & ~btn_q[c];
            release_d[c] = ~btn_d[c] &  btn_q[c];

            // Hold counter only runs while the level is, and stays, pressed.
            // The tick on which o_btn rises leaves it at 0. A tick that also
            // releases the button clears it, so no o_long can coincide with a
            // release. Saturation at HOLD_MAX limits o_long to one per press.
            if (btn_q[c] && btn_d[c]) begin
                hold_d[c] = hold_q[c];
                if (clk_flag && (hold_q[c] != HOLD_MAX)) begin
                    hold_d[c] = hold_q[c] + HOLD_W'(1);
                    long_d[c] = LONG_EN && (hold_q[c] == HOLD_LAST);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            btn_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            for (int c = 0; c < CH; c++) begin
                cnt_q[c]  <= '0;
                hold_q[c] <= '0;
            end
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            btn_q     <= btn_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            for (int c = 0; c < CH; c++) begin
                cnt_q[c]  <= cnt_d[c];
                hold_q[c] <= hold_d[c];
            end
        end
    end

    assign o_btn     = btn_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_long    = long_q;

endmodule
